// File: rtl/risc_pkg.sv
// Shared definitions for the RISC program-counter unit: FSM state encoding,
// next-PC select encoding and default sizing constants.
package risc_pkg;

   localparam int unsigned PC_W_DEF      = 8;
   localparam int unsigned RAS_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      NPC_HOLD = 2'd0,
      NPC_POP  = 2'd1,
      NPC_BR   = 2'd2,
      NPC_INC  = 2'd3
   } npc_sel_e;

endpackage

// File: rtl/risc_ras.sv
// Hardware return-address stack: circular LIFO with write pointer and entry
// count. A push while full overwrites the oldest entry; sticky overflow and
// underflow flags clear only on reset. Push and pop are never requested together.
module risc_ras
   import risc_pkg::*;
#(
   parameter int unsigned PC_W      = PC_W_DEF,
   parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [PC_W-1:0] push_data_i,
   output logic [PC_W-1:0] pop_data_o,
   output logic            empty_o,
   output logic            full_o,
   output logic            ovf_o,
   output logic            unf_o
);

   localparam int unsigned PtrW = $clog2(RAS_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [PC_W-1:0] mem_q [RAS_DEPTH];
   logic [PtrW-1:0] ptr_q, ptr_d, top_idx;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            ovf_q, ovf_d, unf_q, unf_d;

   // ptr_q is the next write slot, so the newest entry sits one below it;
   // when full it also points at the oldest entry, which a push overwrites.
   assign top_idx    = ptr_q - PtrW'(1);
   assign pop_data_o = mem_q[top_idx];
   assign empty_o    = (cnt_q == '0);
   assign full_o     = (cnt_q == CntW'(RAS_DEPTH));
   assign ovf_o      = ovf_q;
   assign unf_o      = unf_q;

   // Pointer, count and sticky flag next-state
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (push_i) begin
         ptr_d = ptr_q + PtrW'(1);
         if (full_o) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end else if (pop_i) begin
         if (empty_o) begin
            unf_d = 1'b1;
         end else begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CntW'(1);
         end
      end
   end

   // Control state with synchronous reset; reset discards all entries
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Entry storage; contents are qualified by the count so need no reset
   always_ff @(posedge clk) begin
      if (push_i && !reset) begin
         mem_q[ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/risc_pc_unit.sv
// Program-counter and fetch-sequencing unit: BOOT/RUN/HALT sequencing, stall,
// taken branches and call/return. The return-address stack is built only when
// PC_UNIT_RAS_EN is defined; otherwise call is ignored, ret increments and the
// stack flags are tied constants.
module risc_pc_unit
   import risc_pkg::*;
#(
   parameter int unsigned PC_W      = PC_W_DEF,
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned STEP      = 1,
   parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            halt,
   input  logic            resume,
   input  logic            br_valid,
   input  logic [PC_W-1:0] br_target,
   input  logic            call,
   input  logic            ret,
   output logic [PC_W-1:0] pc,
   output logic            pc_valid,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_ovf,
   output logic            ras_unf
);

   localparam logic [PC_W-1:0] StepV   = PC_W'(STEP);
   localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_PC);

`ifdef PC_UNIT_RAS_EN
   localparam bit RasEn = 1'b1;
`else
   localparam bit RasEn = 1'b0;
`endif

   state_e          state_q, state_d;
   npc_sel_e        npc_sel;
   logic [PC_W-1:0] pc_q, pc_d, pc_inc, pop_data;
   logic            pc_valid_q;
   logic            push, pop, stack_empty;

   assign pc_inc   = pc_q + StepV;
   assign pc       = pc_q;
   assign pc_valid = pc_valid_q;

   // FSM next-state; halt beats resume because resume is only looked at in HALT
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN:  if (halt) state_d = ST_HALT;
         ST_HALT: if (resume) state_d = ST_RUN;
         default: state_d = ST_BOOT;
      endcase
   end

   // Next-PC select; halting, stalled or non-RUN cycles hold and touch no stack
   always_comb begin
      npc_sel = NPC_HOLD;
      push    = 1'b0;
      if (state_q == ST_RUN && !halt && !stall) begin
         if (ret) begin
            npc_sel = RasEn ? NPC_POP : NPC_INC;
         end else if (br_valid) begin
            npc_sel = NPC_BR;
            push    = RasEn && call;
         end else begin
            npc_sel = NPC_INC;
         end
      end
   end

   assign pop = (npc_sel == NPC_POP);

   // Next-PC mux; a pop from an empty stack falls back to a sequential step
   always_comb begin
      pc_d = pc_q;
      case (npc_sel)
         NPC_HOLD: pc_d = pc_q;
         NPC_POP:  pc_d = stack_empty ? pc_inc : pop_data;
         NPC_BR:   pc_d = br_target;
         NPC_INC:  pc_d = pc_inc;
         default:  pc_d = pc_q;
      endcase
   end

   // Registered PC, FSM state and fetch-valid
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_BOOT;
         pc_q       <= ResetPc;
         pc_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_valid_q <= (state_d == ST_RUN);
      end
   end

`ifdef PC_UNIT_RAS_EN
   risc_ras #(
      .PC_W      (PC_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .pop_i       (pop),
      .push_data_i (pc_inc),
      .pop_data_o  (pop_data),
      .empty_o     (stack_empty),
      .full_o      (ras_full),
      .ovf_o       (ras_ovf),
      .unf_o       (ras_unf)
   );
   assign ras_empty = stack_empty;
`else
   logic unused_ras;
   assign unused_ras  = ^{push, pop, call};
   assign pop_data    = '0;
   assign stack_empty = 1'b1;
   assign ras_empty   = 1'b1;
   assign ras_full    = 1'b0;
   assign ras_ovf     = 1'b0;
   assign ras_unf     = 1'b0;
`endif

endmodule

// File: tb/tb_risc_pc_unit.sv
// Directed self-checking bench for risc_pc_unit. Expected values are written by
// hand for both builds (with and without PC_UNIT_RAS_EN).
module tb_risc_pc_unit;
   import risc_pkg::*;

`ifdef PC_UNIT_RAS_EN
   localparam bit RasEn = 1'b1;
`else
   localparam bit RasEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, stall, halt, resume, br_valid, call, ret;
   logic [7:0] br_target;
   logic [7:0] pc, pc2;
   logic       pc_valid, ras_empty, ras_full, ras_ovf, ras_unf;
   logic       pc_valid2, ras_empty2, ras_full2, ras_ovf2, ras_unf2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   risc_pc_unit #(
      .PC_W      (8),
      .RESET_PC  (0),
      .STEP      (1),
      .RAS_DEPTH (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .halt      (halt),
      .resume    (resume),
      .br_valid  (br_valid),
      .br_target (br_target),
      .call      (call),
      .ret       (ret),
      .pc        (pc),
      .pc_valid  (pc_valid),
      .ras_empty (ras_empty),
      .ras_full  (ras_full),
      .ras_ovf   (ras_ovf),
      .ras_unf   (ras_unf)
   );

   // Second instance only to check a non-zero reset address
   risc_pc_unit #(
      .PC_W      (8),
      .RESET_PC  (32'h10),
      .STEP      (1),
      .RAS_DEPTH (4)
   ) dut_rst10 (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .halt      (halt),
      .resume    (resume),
      .br_valid  (br_valid),
      .br_target (br_target),
      .call      (call),
      .ret       (ret),
      .pc        (pc2),
      .pc_valid  (pc_valid2),
      .ras_empty (ras_empty2),
      .ras_full  (ras_full2),
      .ras_ovf   (ras_ovf2),
      .ras_unf   (ras_unf2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pc(input string tag, input logic [7:0] exp_pc, input logic exp_valid);
      chk({tag, ".pc"}, {24'h0, pc}, {24'h0, exp_pc});
      chk({tag, ".valid"}, {31'h0, pc_valid}, {31'h0, exp_valid});
   endtask

   task automatic chk_flags(input string tag, input logic e, input logic f, input logic o,
                            input logic u);
      chk({tag, ".flags"}, {28'h0, ras_empty, ras_full, ras_ovf, ras_unf},
          {28'h0, e, f, o, u});
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; halt = 1'b0; resume = 1'b0;
      br_valid = 1'b0; br_target = 8'h00; call = 1'b0; ret = 1'b0;
      tick();
      tick();
      // Reset state; still BOOT-side while reset is low for the first cycle
      chk_pc("reset", 8'h00, 1'b0);
      chk_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("reset.pc_rst10", {24'h0, pc2}, 32'h10);
      reset = 1'b0;
      #1;
      chk("boot.valid", {31'h0, pc_valid}, 32'h0);
      tick();
      chk_pc("run0", 8'h00, 1'b1);
      chk("run0.pc_rst10", {24'h0, pc2}, 32'h10);
      chk("run0.valid_rst10", {31'h0, pc_valid2}, 32'h1);
      tick();
      chk_pc("run1", 8'h01, 1'b1);
      tick();
      chk_pc("run2", 8'h02, 1'b1);

      // Wrap-around from 0xFE
      br_valid = 1'b1; br_target = 8'hFE;
      tick();
      chk_pc("wrap_fe", 8'hFE, 1'b1);
      br_valid = 1'b0;
      tick();
      chk_pc("wrap_ff", 8'hFF, 1'b1);
      tick();
      chk_pc("wrap_00", 8'h00, 1'b1);
      chk_flags("wrap", 1'b1, 1'b0, 1'b0, 1'b0);

      // Branch, with a stall on the same edge first
      br_valid = 1'b1; br_target = 8'h05;
      tick();
      chk_pc("br05", 8'h05, 1'b1);
      br_target = 8'h40; stall = 1'b1;
      tick();
      chk_pc("br_stall", 8'h05, 1'b1);
      stall = 1'b0;
      tick();
      chk_pc("br40", 8'h40, 1'b1);
      br_valid = 1'b0;
      tick();
      chk_pc("br41", 8'h41, 1'b1);

      // Single call/return
      br_valid = 1'b1; br_target = 8'h05;
      tick();
      chk_pc("call_pre", 8'h05, 1'b1);
      call = 1'b1; br_target = 8'h40;
      tick();
      chk_pc("call40", 8'h40, 1'b1);
      chk_flags("call40", !RasEn, 1'b0, 1'b0, 1'b0);
      call = 1'b0; br_valid = 1'b0;
      tick();
      tick();
      tick();
      chk_pc("body43", 8'h43, 1'b1);
      ret = 1'b1;
      tick();
      chk_pc("ret", RasEn ? 8'h06 : 8'h44, 1'b1);
      chk_flags("ret", 1'b1, 1'b0, 1'b0, 1'b0);
      ret = 1'b0;

      // Five nested calls into a four-deep stack
      br_valid = 1'b1; call = 1'b1;
      br_target = 8'h10; tick();
      br_target = 8'h20; tick();
      br_target = 8'h30; tick();
      br_target = 8'h40; tick();
      chk_pc("nest4", 8'h40, 1'b1);
      chk_flags("nest4", !RasEn, RasEn, 1'b0, 1'b0);
      br_target = 8'h50; tick();
      chk_pc("nest5", 8'h50, 1'b1);
      chk_flags("nest5", !RasEn, RasEn, RasEn, 1'b0);
      br_valid = 1'b0; call = 1'b0; ret = 1'b1;
      tick();
      chk_pc("pop1", RasEn ? 8'h41 : 8'h51, 1'b1);
      tick();
      chk_pc("pop2", RasEn ? 8'h31 : 8'h52, 1'b1);
      tick();
      chk_pc("pop3", RasEn ? 8'h21 : 8'h53, 1'b1);
      tick();
      chk_pc("pop4", RasEn ? 8'h11 : 8'h54, 1'b1);
      chk_flags("pop4", 1'b1, 1'b0, RasEn, 1'b0);
      tick();
      chk_pc("pop5", RasEn ? 8'h12 : 8'h55, 1'b1);
      chk_flags("pop5", 1'b1, 1'b0, RasEn, RasEn);
      ret = 1'b0;

      // Halt / resume
      br_valid = 1'b1; br_target = 8'h20;
      tick();
      br_valid = 1'b0; halt = 1'b1;
      tick();
      chk_pc("halt", 8'h20, 1'b0);
      halt = 1'b0;
      tick();
      tick();
      chk_pc("halted", 8'h20, 1'b0);
      resume = 1'b1;
      tick();
      chk_pc("resume", 8'h20, 1'b1);
      resume = 1'b0;
      tick();
      chk_pc("resume_inc", 8'h21, 1'b1);
      halt = 1'b1; resume = 1'b1;
      tick();
      chk_pc("halt_wins", 8'h21, 1'b0);
      halt = 1'b0;
      tick();
      chk_pc("resume2", 8'h21, 1'b1);
      resume = 1'b0;

      // Two stacked entries, halt, then reset while halted
      br_valid = 1'b1; call = 1'b1;
      br_target = 8'h60; tick();
      br_target = 8'h70; tick();
      chk_pc("stack2", 8'h70, 1'b1);
      chk_flags("stack2", !RasEn, 1'b0, RasEn, RasEn);
      br_valid = 1'b0; call = 1'b0; halt = 1'b1;
      tick();
      chk_pc("halt2", 8'h70, 1'b0);
      halt = 1'b0; reset = 1'b1;
      tick();
      chk_pc("rst_halt", 8'h00, 1'b0);
      chk_flags("rst_halt", 1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      chk_pc("rst_run", 8'h00, 1'b1);
      ret = 1'b1;
      tick();
      chk_pc("ret_empty", 8'h01, 1'b1);
      chk_flags("ret_empty", 1'b1, 1'b0, 1'b0, RasEn);
      ret = 1'b0;
      tick();
      chk_pc("final", 8'h02, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
